// File: rtl/pulse_frequency_meter_pkg.sv
// Shared definitions for the pixel period meter: state encoding, accumulator width,
// period classes and the band-bound / saturating-add helpers.
package pulse_frequency_meter_pkg;

    localparam int unsigned AccWidth = 32;

    typedef logic [AccWidth-1:0] acc_t;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArm     = 2'd1;
    localparam logic [1:0] StMeasure = 2'd2;

    typedef enum logic [1:0] {
        ClsF0      = 2'd0,
        ClsF1      = 2'd1,
        ClsUnknown = 2'd2
    } period_class_e;

    // Period bound in clocks for a frequency band; upper selects the long (slow) edge.
    function automatic int unsigned band_bound(input int unsigned clk_hz,
                                               input int unsigned freq_hz,
                                               input int unsigned dev_hz,
                                               input logic        upper);
        return upper ? clk_hz / (freq_hz - dev_hz) : clk_hz / (freq_hz + dev_hz);
    endfunction

    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        logic [AccWidth:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[AccWidth] ? '1 : sum[AccWidth-1:0];
    endfunction

endpackage

// File: rtl/pulse_frequency_meter_sync.sv
// Two-flop synchronizer followed by a registered single-cycle rising-edge pulse.
module signal_edge_synchronizer (
    input  logic clock,
    input  logic resetn,
    input  logic data_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pulse_frequency_meter.sv
// Measures periods between rising edges of one pixel's sample stream, classifies each
// against two frequency bands and accumulates period lengths into saturating registers.
module pulse_frequency_meter
    import pulse_frequency_meter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY      = 100000000,
    parameter int unsigned FREQUENCY0           = 7500,
    parameter int unsigned FREQUENCY1           = 10000,
    parameter int unsigned FREQUENCY0_DEVIATION = 30,
    parameter int unsigned FREQUENCY1_DEVIATION = 30
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                sample_data,
    input  logic                enable,
    input  logic                clear,
    output logic [AccWidth-1:0] f0_value,
    output logic [AccWidth-1:0] f1_value,
    output logic [AccWidth-1:0] unknown,
    output logic                period_valid,
    output logic [AccWidth-1:0] last_period
);

    localparam acc_t P0Min = acc_t'(band_bound(CLOCK_FREQUENCY, FREQUENCY0,
                                               FREQUENCY0_DEVIATION, 1'b0));
    localparam acc_t P0Max = acc_t'(band_bound(CLOCK_FREQUENCY, FREQUENCY0,
                                               FREQUENCY0_DEVIATION, 1'b1));
    localparam acc_t P1Min = acc_t'(band_bound(CLOCK_FREQUENCY, FREQUENCY1,
                                               FREQUENCY1_DEVIATION, 1'b0));
    localparam acc_t P1Max = acc_t'(band_bound(CLOCK_FREQUENCY, FREQUENCY1,
                                               FREQUENCY1_DEVIATION, 1'b1));
    localparam acc_t TimeoutCycles = acc_t'(32'd2 * ((P0Max > P1Max) ? P0Max : P1Max));

    logic          rise;
    logic [1:0]    state_q, state_d;
    acc_t          cnt_q, cnt_d;
    acc_t          f0_q, f0_d;
    acc_t          f1_q, f1_d;
    acc_t          unk_q, unk_d;
    acc_t          last_q, last_d;
    logic          valid_q, valid_d;
    period_class_e cls;

    signal_edge_synchronizer u_sync (
        .clock  (clock),
        .resetn (resetn),
        .data_i (sample_data),
        .rise_o (rise)
    );

    // F0 is tested first so it wins if the two bands overlap.
    always_comb begin
        if (cnt_q >= P0Min && cnt_q <= P0Max) begin
            cls = ClsF0;
        end else if (cnt_q >= P1Min && cnt_q <= P1Max) begin
            cls = ClsF1;
        end else begin
            cls = ClsUnknown;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f0_d    = f0_q;
        f1_d    = f1_q;
        unk_d   = unk_q;
        last_d  = last_q;
        valid_d = 1'b0;
        if (!clear) begin
            state_d = StIdle;
            cnt_d   = '0;
            f0_d    = '0;
            f1_d    = '0;
            unk_d   = '0;
            last_d  = '0;
        end else if (!enable) begin
            // Partial period is dropped; accumulators keep their totals.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArm;
                StArm: begin
                    if (rise) begin
                        state_d = StMeasure;
                        cnt_d   = acc_t'(1);
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        unique case (cls)
                            ClsF0:   f0_d  = sat_add(f0_q, cnt_q);
                            ClsF1:   f1_d  = sat_add(f1_q, cnt_q);
                            default: unk_d = sat_add(unk_q, cnt_q);
                        endcase
                        last_d  = cnt_q;
                        valid_d = 1'b1;
                        cnt_d   = acc_t'(1);
                    end else if (cnt_q >= TimeoutCycles) begin
                        unk_d   = sat_add(unk_q, TimeoutCycles);
                        last_d  = TimeoutCycles;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StArm;
                    end else begin
                        cnt_d = sat_add(cnt_q, acc_t'(1));
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            f0_q    <= '0;
            f1_q    <= '0;
            unk_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            unk_q   <= unk_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign f0_value     = f0_q;
    assign f1_value     = f1_q;
    assign unknown      = unk_q;
    assign last_period  = last_q;
    assign period_valid = valid_q;

endmodule

// File: tb/tb_pulse_frequency_meter.sv
// Scoreboard bench for pulse_frequency_meter. A 10 MHz clock parameter scales every period
// by 1/10: F0 band 1328..1338, F1 band 997..1003, timeout 2676 clocks.
module tb_pulse_frequency_meter;
    import pulse_frequency_meter_pkg::*;

    localparam int ClsF0T  = 0;
    localparam int ClsF1T  = 1;
    localparam int ClsUnkT = 2;

    typedef struct {
        logic [31:0] lp;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] unk;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sample_data;
    logic        enable;
    logic        clear;
    logic [31:0] f0_value;
    logic [31:0] f1_value;
    logic [31:0] unknown;
    logic        period_valid;
    logic [31:0] last_period;

    exp_t        exp_q[$];
    logic [31:0] exp_f0, exp_f1, exp_unk;
    int          vectors = 0;
    int          miscompares = 0;
    int          valid_cnt = 0;

    always #5 clk = ~clk;

    pulse_frequency_meter #(
        .CLOCK_FREQUENCY      (10000000),
        .FREQUENCY0           (7500),
        .FREQUENCY1           (10000),
        .FREQUENCY0_DEVIATION (30),
        .FREQUENCY1_DEVIATION (30)
    ) dut (
        .clock        (clk),
        .resetn       (resetn),
        .sample_data  (sample_data),
        .enable       (enable),
        .clear        (clear),
        .f0_value     (f0_value),
        .f1_value     (f1_value),
        .unknown      (unknown),
        .period_valid (period_valid),
        .last_period  (last_period)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Monitor: every period_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (period_valid) begin
            exp_t e;
            valid_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got pulse at %0t, expected none", $time);
            end else begin
                e = exp_q.pop_front();
                check("last_period", last_period, e.lp);
                check("f0_value", f0_value, e.f0);
                check("f1_value", f1_value, e.f1);
                check("unknown", unknown, e.unk);
            end
        end
    end

    task automatic push_period(input logic [31:0] p, input int cls);
        case (cls)
            ClsF0T:  exp_f0  = sat32(exp_f0, p);
            ClsF1T:  exp_f1  = sat32(exp_f1, p);
            default: exp_unk = sat32(exp_unk, p);
        endcase
        exp_q.push_back('{lp: p, f0: exp_f0, f1: exp_f1, unk: exp_unk});
    endtask

    // First edge only arms; each later edge closes one period of the given class.
    task automatic wave(input int unsigned period, input int unsigned edges, input int cls);
        for (int i = 0; i < int'(edges); i++) begin
            if (i > 0) push_period(period, cls);
            sample_data = 1'b1;
            repeat (period / 2) @(negedge clk);
            sample_data = 1'b0;
            repeat (period - period / 2) @(negedge clk);
        end
    endtask

    task automatic rearm();
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: got no finish, expected finish within 100000 clocks");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_f0      = '0;
        exp_f1      = '0;
        exp_unk     = '0;
        resetn      = 1'b0;
        sample_data = 1'b0;
        enable      = 1'b0;
        clear       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_f0", f0_value, 32'd0);
        check("reset_valid", {31'd0, period_valid}, 32'd0);
        resetn = 1'b1;

        // Disabled: toggling input must not produce anything.
        for (int i = 0; i < 1000; i++) begin
            if (i % 3 == 0) sample_data = ~sample_data;
            @(negedge clk);
        end
        sample_data = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_f0", f0_value, 32'd0);
        check("idle_f1", f1_value, 32'd0);
        check("idle_unknown", unknown, 32'd0);
        check("idle_last", last_period, 32'd0);
        check("idle_valid_cnt", valid_cnt, 32'd0);

        rearm();
        wave(1333, 6, ClsF0T);
        check("f0_total", f0_value, 32'd6665);
        check("f0_last", last_period, 32'd1333);
        check("f0_pulses", valid_cnt, 32'd5);

        rearm();
        wave(1000, 5, ClsF1T);
        check("f1_total", f1_value, 32'd4000);
        rearm();
        wave(1200, 4, ClsUnkT);
        check("unk_total", unknown, 32'd3600);
        check("f0_hold", f0_value, 32'd6665);

        // Single edge then silence: timeout at 2676 clocks, then the next edge only arms.
        rearm();
        push_period(32'd2676, ClsUnkT);
        sample_data = 1'b1;
        repeat (50) @(negedge clk);
        sample_data = 1'b0;
        repeat (2950) @(negedge clk);
        check("timeout_unk", unknown, 32'd6276);
        check("timeout_state", {30'd0, dut.state_q}, {30'd0, StArm});
        wave(1333, 2, ClsF0T);
        check("post_timeout_f0", f0_value, 32'd7998);

        // Clear coincides with a rise that would close an F0 period.
        sample_data = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        exp_f0  = '0;
        exp_f1  = '0;
        exp_unk = '0;
        repeat (600) @(negedge clk);
        sample_data = 1'b0;
        repeat (20) @(negedge clk);
        check("clear_f0", f0_value, 32'd0);
        check("clear_f1", f1_value, 32'd0);
        check("clear_unknown", unknown, 32'd0);
        check("clear_last", last_period, 32'd0);

        // Enable falls on the same cycle the closing rise is consumed.
        repeat (700) @(negedge clk);
        sample_data = 1'b1;
        repeat (666) @(negedge clk);
        sample_data = 1'b0;
        repeat (667) @(negedge clk);
        sample_data = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (700) @(negedge clk);
        sample_data = 1'b0;
        repeat (20) @(negedge clk);
        check("drop_f0", f0_value, 32'd0);
        check("drop_unknown", unknown, 32'd0);
        check("drop_state", {30'd0, dut.state_q}, {30'd0, StIdle});

        // Saturation: preload F0 near full scale, then add one F0 period.
        enable = 1'b1;
        repeat (4) @(negedge clk);
        force dut.f0_q = 32'hFFFF_FF00;
        @(negedge clk);
        release dut.f0_q;
        exp_f0 = 32'hFFFF_FF00;
        wave(1333, 2, ClsF0T);
        check("sat_f0", f0_value, 32'hFFFF_FFFF);

        repeat (10) @(negedge clk);
        check("pending_expect", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
